axi_lite_apb_bridge: RTL and testbench

AXI4-Lite slave to APB master bridge. It sits between the RISC-V core's AXI-Lite master port and the APB peripheral bus, which hosts the UART and its TX/RX FIFOs. It converts one AXI-Lite read or write at a time into a single APB SETUP/ACCESS transfer and returns the APB result as an AXI response. A PREADY timeout guarantees that a hung peripheral cannot lock up the core.

---
 rtl/axi_lite_apb_bridge_if.sv | 53 +++++
 rtl/axi_lite_apb_bridge.sv | 148 ++++++++++++++
 tb/tb_axi_lite_apb_bridge.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_apb_bridge_if.sv
// Bus bundle between the core's AXI-Lite master and the APB peripheral side.
// slave = the bridge's view; master = the core/peripheral environment view.
interface axi_lite_apb_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARVALID, RREADY,
        input  PRDATA, PREADY, PSLVERR,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RVALID,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARVALID, RREADY,
        output PRDATA, PREADY, PSLVERR,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RVALID,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
    );
endinterface

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge: one transfer at a time, read/write
// alternation on ties, PREADY timeout forcing SLVERR.
module axi_lite_apb_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    axi_lite_apb_bridge_if.slave  bus,
    output logic [2:0]            bridge_state
);
    localparam int STRB_W = DATA_W / 8;
    // Counter only has to reach TIMEOUT_CYCLES-1; the abort fires on that wait cycle.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic [STRB_W-1:0] pstrb_reg;
    logic              pwrite_reg;
    logic [1:0]        resp_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              last_was_write_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;

    logic write_cand, read_cand;
    logic grant_write, grant_read;
    logic access_done, access_timeout;

    assign write_cand = bus.AWVALID && bus.WVALID;
    assign read_cand  = bus.ARVALID;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_write    = 1'b0;
        grant_read     = 1'b0;
        access_done    = 1'b0;
        access_timeout = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Readies are combinational, so gate them with reset explicitly.
                if (areset_n) begin
                    if (read_cand && (!write_cand || last_was_write_reg)) begin
                        grant_read = 1'b1;
                    end else if (write_cand) begin
                        grant_write = 1'b1;
                    end
                end
                if (grant_read || grant_write) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: state_next = S_ACCESS;
            S_ACCESS: begin
                if (bus.PREADY) begin
                    access_done = 1'b1;
                    state_next  = S_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_reg == TIMEOUT_LAST)) begin
                    access_timeout = 1'b1;
                    state_next     = S_RESP;
                end
            end
            S_RESP: begin
                if (pwrite_reg ? bus.BREADY : bus.RREADY) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            paddr_reg          <= '0;
            pwdata_reg         <= '0;
            pstrb_reg          <= '0;
            pwrite_reg         <= 1'b0;
            resp_reg           <= 2'b00;
            rdata_reg          <= '0;
            last_was_write_reg <= 1'b0;
            wait_cnt_reg       <= '0;
        end else begin
            if (grant_write) begin
                paddr_reg          <= bus.AWADDR;
                pwdata_reg         <= bus.WDATA;
                pstrb_reg          <= bus.WSTRB;
                pwrite_reg         <= 1'b1;
                last_was_write_reg <= 1'b1;
            end else if (grant_read) begin
                paddr_reg          <= bus.ARADDR;
                pstrb_reg          <= '0;
                pwrite_reg         <= 1'b0;
                last_was_write_reg <= 1'b0;
            end

            if (grant_write || grant_read) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == S_ACCESS && !bus.PREADY) begin
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end

            if (access_done) begin
                resp_reg <= bus.PSLVERR ? 2'b10 : 2'b00;
                if (!pwrite_reg) begin
                    rdata_reg <= bus.PRDATA;
                end
            end else if (access_timeout) begin
                resp_reg <= 2'b10;
                if (!pwrite_reg) begin
                    rdata_reg <= '0;
                end
            end
        end
    end

    assign bus.AWREADY = grant_write;
    assign bus.WREADY  = grant_write;
    assign bus.ARREADY = grant_read;
    assign bus.PADDR   = paddr_reg;
    assign bus.PWDATA  = pwdata_reg;
    assign bus.PSTRB   = pstrb_reg;
    assign bus.PWRITE  = pwrite_reg;
    assign bus.PSEL    = (state_reg == S_SETUP) || (state_reg == S_ACCESS);
    assign bus.PENABLE = (state_reg == S_ACCESS);
    assign bus.BVALID  = (state_reg == S_RESP) && pwrite_reg;
    assign bus.RVALID  = (state_reg == S_RESP) && !pwrite_reg;
    assign bus.BRESP   = resp_reg;
    assign bus.RRESP   = resp_reg;
    assign bus.RDATA   = rdata_reg;
    assign bridge_state = {1'b0, state_reg};
endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Directed bench for axi_lite_apb_bridge with TIMEOUT_CYCLES=4.
module tb_axi_lite_apb_bridge;
    logic       aclk;
    logic       areset_n;
    logic [2:0] bridge_state;
    int         n_checks;
    int         n_fail;
    int         acc_cycles;

    axi_lite_apb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_apb_bridge #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) u_dut (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .bus          (bus.slave),
        .bridge_state (bridge_state)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(negedge aclk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        areset_n = 1'b0;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        repeat (2) cyc();

        // Reset values, with all requests already pending
        bus.AWADDR = 32'h1000_0004; bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h1000_0008; bus.ARVALID = 1'b1;
        #1;
        chk("rst PSEL", bus.PSEL, 0);       chk("rst PENABLE", bus.PENABLE, 0);
        chk("rst PADDR", bus.PADDR, 0);     chk("rst PWDATA", bus.PWDATA, 0);
        chk("rst PSTRB", bus.PSTRB, 0);     chk("rst PWRITE", bus.PWRITE, 0);
        chk("rst BVALID", bus.BVALID, 0);   chk("rst BRESP", bus.BRESP, 0);
        chk("rst RVALID", bus.RVALID, 0);   chk("rst RRESP", bus.RRESP, 0);
        chk("rst RDATA", bus.RDATA, 0);     chk("rst state", bridge_state, 0);
        chk("rst AWREADY", bus.AWREADY, 0); chk("rst WREADY", bus.WREADY, 0);
        chk("rst ARREADY", bus.ARREADY, 0);

        // Tie right after reset: write wins (c0)
        areset_n = 1'b1;
        bus.PREADY = 1'b1; bus.PRDATA = 32'h0000_00A5;
        #1;
        chk("tie1 AWREADY", bus.AWREADY, 1); chk("tie1 WREADY", bus.WREADY, 1);
        chk("tie1 ARREADY", bus.ARREADY, 0);
        cyc(); bus.AWVALID = 1'b0; bus.WVALID = 1'b0; #1;              // c1 SETUP
        chk("wr1 setup state", bridge_state, 1);
        chk("wr1 setup PSEL", bus.PSEL, 1); chk("wr1 setup PENABLE", bus.PENABLE, 0);
        cyc(); #1;                                                      // c2 ACCESS
        chk("wr1 acc state", bridge_state, 2);
        chk("wr1 acc PSEL", bus.PSEL, 1);     chk("wr1 acc PENABLE", bus.PENABLE, 1);
        chk("wr1 acc PADDR", bus.PADDR, 32'h1000_0004);
        chk("wr1 acc PWDATA", bus.PWDATA, 32'hDEAD_BEEF);
        chk("wr1 acc PSTRB", bus.PSTRB, 4'hF); chk("wr1 acc PWRITE", bus.PWRITE, 1);
        cyc(); #1;                                                      // c3 RESP
        chk("wr1 BVALID", bus.BVALID, 1); chk("wr1 BRESP", bus.BRESP, 0);
        chk("wr1 resp ARREADY", bus.ARREADY, 0);
        $display("txn write addr=0x10000004 data=0xdeadbeef bresp=%0d", bus.BRESP);

        // Repeat the tie in the next IDLE: read wins now (c4)
        bus.AWADDR = 32'h1000_0010; bus.WDATA = 32'h1234_5678; bus.WSTRB = 4'h3;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        cyc(); bus.PREADY = 1'b0; #1;
        chk("tie2 state", bridge_state, 0); chk("tie2 BVALID", bus.BVALID, 0);
        chk("tie2 ARREADY", bus.ARREADY, 1); chk("tie2 AWREADY", bus.AWREADY, 0);
        cyc(); bus.ARVALID = 1'b0; #1;                                  // c5 SETUP
        chk("rd1 setup PSEL", bus.PSEL, 1); chk("rd1 setup PENABLE", bus.PENABLE, 0);
        chk("rd1 setup PADDR", bus.PADDR, 32'h1000_0008);
        chk("rd1 setup PSTRB", bus.PSTRB, 0); chk("rd1 setup PWRITE", bus.PWRITE, 0);
        chk("rd1 setup PWDATA held", bus.PWDATA, 32'hDEAD_BEEF);
        chk("rd1 busy AWREADY", bus.AWREADY, 0);
        for (int i = 0; i < 3; i++) begin                               // c6..c8 waits
            cyc(); #1;
            chk("rd1 wait state", bridge_state, 2); chk("rd1 wait PSTRB", bus.PSTRB, 0);
            chk("rd1 wait RVALID", bus.RVALID, 0);
        end
        cyc(); bus.PREADY = 1'b1; #1;                                   // c9 ACCESS ready
        chk("rd1 acc PENABLE", bus.PENABLE, 1);
        cyc(); #1;                                                      // c10 RESP
        chk("rd1 RVALID", bus.RVALID, 1); chk("rd1 RDATA", bus.RDATA, 32'h0000_00A5);
        chk("rd1 RRESP", bus.RRESP, 0);   chk("rd1 resp PSEL", bus.PSEL, 0);
        $display("txn read addr=0x10000008 rdata=0x%08h rresp=%0d", bus.RDATA, bus.RRESP);

        // Held write now granted, completes with PSLVERR
        cyc(); bus.PSLVERR = 1'b1; #1;
        chk("wr2 AWREADY", bus.AWREADY, 1); chk("wr2 state", bridge_state, 0);
        cyc(); bus.AWVALID = 1'b0; bus.WVALID = 1'b0; #1;
        chk("wr2 setup PSTRB", bus.PSTRB, 4'h3);
        cyc(); #1;
        chk("wr2 acc PADDR", bus.PADDR, 32'h1000_0010);
        chk("wr2 acc PWDATA", bus.PWDATA, 32'h1234_5678);
        cyc(); #1;
        chk("wr2 BVALID", bus.BVALID, 1); chk("wr2 BRESP", bus.BRESP, 2'b10);
        $display("txn write addr=0x10000010 data=0x12345678 bresp=%0d", bus.BRESP);

        // Read with PSLVERR
        cyc(); bus.ARADDR = 32'h1000_000C; bus.ARVALID = 1'b1; bus.PRDATA = 32'h5A5A_0001; #1;
        chk("rd2 ARREADY", bus.ARREADY, 1);
        cyc(); bus.ARVALID = 1'b0;
        cyc();
        cyc(); #1;
        chk("rd2 RVALID", bus.RVALID, 1); chk("rd2 RRESP", bus.RRESP, 2'b10);
        chk("rd2 RDATA", bus.RDATA, 32'h5A5A_0001);
        $display("txn read addr=0x1000000c rdata=0x%08h rresp=%0d", bus.RDATA, bus.RRESP);
        bus.PSLVERR = 1'b0;

        // Write timeout
        cyc(); bus.AWADDR = 32'h1000_0014; bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.PREADY = 1'b0; #1;
        chk("wto AWREADY", bus.AWREADY, 1);
        cyc(); bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        acc_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            if (bridge_state == 3'd2) acc_cycles++;
            if (bridge_state == 3'd3) break;
        end
        chk("wto access cycles", acc_cycles, 4);
        chk("wto PSEL", bus.PSEL, 0); chk("wto BVALID", bus.BVALID, 1);
        chk("wto BRESP", bus.BRESP, 2'b10);
        $display("txn write addr=0x10000014 timeout bresp=%0d", bus.BRESP);

        // Read timeout
        cyc(); bus.ARADDR = 32'h1000_0018; bus.ARVALID = 1'b1; bus.PRDATA = 32'hFFFF_FFFF; #1;
        chk("rto ARREADY", bus.ARREADY, 1);
        cyc(); bus.ARVALID = 1'b0;
        acc_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            if (bridge_state == 3'd2) acc_cycles++;
            if (bridge_state == 3'd3) break;
        end
        chk("rto access cycles", acc_cycles, 4);
        chk("rto PSEL", bus.PSEL, 0); chk("rto RVALID", bus.RVALID, 1);
        chk("rto RRESP", bus.RRESP, 2'b10); chk("rto RDATA", bus.RDATA, 0);
        $display("txn read addr=0x10000018 timeout rdata=0x%08h rresp=%0d", bus.RDATA, bus.RRESP);

        // BREADY stall for 5 cycles
        cyc(); bus.BREADY = 1'b0; bus.PREADY = 1'b1;
        bus.AWADDR = 32'h1000_001C; bus.WDATA = 32'h00C0_FFEE; bus.WSTRB = 4'h1;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; #1;
        chk("stall AWREADY", bus.AWREADY, 1);
        cyc(); bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk("stall BVALID", bus.BVALID, 1); chk("stall BRESP", bus.BRESP, 0);
            chk("stall state", bridge_state, 3);
        end
        bus.BREADY = 1'b1;
        cyc(); #1;
        chk("stall release state", bridge_state, 0); chk("stall release BVALID", bus.BVALID, 0);
        $display("txn write addr=0x1000001c stalled 5 cycles bresp=%0d", bus.BRESP);

        // Reset pulse during ACCESS of a read
        bus.ARADDR = 32'h1000_0020; bus.ARVALID = 1'b1; bus.PREADY = 1'b0; #1;
        chk("rstmid ARREADY", bus.ARREADY, 1);
        cyc(); bus.ARVALID = 1'b0;
        cyc(); #1;
        chk("rstmid pre state", bridge_state, 2);
        #2; areset_n = 1'b0; #1;
        chk("rstmid PSEL", bus.PSEL, 0);     chk("rstmid PENABLE", bus.PENABLE, 0);
        chk("rstmid state", bridge_state, 0); chk("rstmid RVALID", bus.RVALID, 0);
        chk("rstmid BVALID", bus.BVALID, 0);  chk("rstmid PADDR", bus.PADDR, 0);
        cyc(); areset_n = 1'b1; bus.PREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("post-rst RVALID", bus.RVALID, 0); chk("post-rst state", bridge_state, 0);
        end
        $display("txn read addr=0x10000020 dropped by reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
